// File: rtl/hazard_md_ctrl.sv
// hazard_md_ctrl: pipeline stall/flush controller with RAW hazard detection and MDU busy sequencer.
// Defining HAZARD_STAT_EN adds a saturating stall-cycle counter on stall_cnt.
module hazard_md_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic        D_rs_use,
    input  logic        D_rt_use,
    input  logic [3:0]  D_rs_Tuse,
    input  logic [3:0]  D_rt_Tuse,
    input  logic        D_md_op,
    input  logic [4:0]  E_A3,
    input  logic        E_Reg_Write,
    input  logic [3:0]  E_Tnew,
    input  logic [4:0]  M_A3,
    input  logic        M_Reg_Write,
    input  logic [3:0]  M_Tnew,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        PC_WE,
    output logic        F_D_WE,
    output logic        D_E_clear,
    output logic        E_M_RegWE,
    output logic        E_M_clear,
    output logic        md_busy,
    output logic        stall,
    output logic [31:0] stall_cnt
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    logic             state;
    logic [CNT_W-1:0] cnt;
    logic             haz_rs;
    logic             haz_rt;
    logic             md_haz;

    // A source hazards only when a producer's result arrives later than the consumer needs it.
    always_comb begin
        haz_rs = D_rs_use && (D_rs != 5'd0) &&
                 ((E_Reg_Write && (E_A3 == D_rs) && (E_Tnew > D_rs_Tuse)) ||
                  (M_Reg_Write && (M_A3 == D_rs) && (M_Tnew > D_rs_Tuse)));
        haz_rt = D_rt_use && (D_rt != 5'd0) &&
                 ((E_Reg_Write && (E_A3 == D_rt) && (E_Tnew > D_rt_Tuse)) ||
                  (M_Reg_Write && (M_A3 == D_rt) && (M_Tnew > D_rt_Tuse)));
        md_haz = D_md_op && (md_busy || E_md_start);
    end

    always_comb begin
        stall     = haz_rs || haz_rt || md_haz;
        PC_WE     = !stall;
        F_D_WE    = !stall;
        D_E_clear = stall;
        E_M_RegWE = 1'b1;
        E_M_clear = 1'b0;
        md_busy   = (state == ST_BUSY);
    end

    // Starts arriving while BUSY are dropped; D is held so legal flow never issues one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (E_md_start) begin
                        state <= ST_BUSY;
                        cnt   <= E_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    end
                end
                ST_BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_STAT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    always_comb begin
        stall_cnt = '0;
    end
`endif

endmodule
